// File: rtl/ndn_pkt_parser_if.sv
// Packet stream bundle for ndn_pkt_parser: upstream (in_*) and downstream (out_*) word streams.
// The master modport is the surrounding environment; the slave modport is the parser.
interface ndn_pkt_parser_if;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/ndn_pkt_parser.sv
// NDN packet parser: forwards the word stream with one cycle of latency and extracts IP/NDN header fields.
// Define NDN_PARSER_STATS_EN to add the pkt_cnt / err_cnt statistics outputs.
module ndn_pkt_parser #(
  parameter logic [31:0] NDN_TYPE = 32'h89ABCDEF
) (
  input  logic                clk,
  input  logic                rst,
  ndn_pkt_parser_if.slave     bus,
  output logic                hdr_valid,
  output logic [15:0]         ip_len,
  output logic [31:0]         ndn_type,
  output logic [15:0]         ndn_len,
  output logic [7:0]          word_cnt,
  output logic                type_match,
  output logic                pkt_err
`ifdef NDN_PARSER_STATS_EN
  ,
  output logic [31:0]         pkt_cnt,
  output logic [15:0]         err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IP1,
    S_IP2,
    S_NDN,
    S_PAYLOAD
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        w_accept;
  logic        w_boundary;
  logic        w_cnt_load;
  logic        w_cnt_inc;
  logic        w_ld_ip;
  logic        w_ld_ndn;
  logic        w_done_ok;
  logic        w_done_err;
  logic [7:0]  w_cnt_sat;

  logic [63:0] r_out_data;
  logic [7:0]  r_out_ctrl;
  logic        r_out_wr;
  logic [7:0]  r_cnt;
  logic [15:0] r_ip_len_nxt;
  logic [31:0] r_ndn_type_nxt;
  logic [15:0] r_ndn_len_nxt;
  logic        r_hdr_valid;
  logic [15:0] r_ip_len;
  logic [31:0] r_ndn_type;
  logic [15:0] r_ndn_len;
  logic [7:0]  r_word_cnt;
  logic        r_type_match;
  logic        r_pkt_err;

  // Back-pressure is passed straight through; there is no internal buffering.
  assign bus.in_rdy = bus.out_rdy;
  assign w_accept   = bus.in_wr && bus.out_rdy;
  assign w_boundary = (bus.in_ctrl != 8'h00);
  assign w_cnt_sat  = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_inc    = 1'b0;
    w_ld_ip      = 1'b0;
    w_ld_ndn     = 1'b0;
    w_done_ok    = 1'b0;
    w_done_err   = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (w_boundary) begin
            w_cnt_load   = 1'b1;
            w_next_state = S_IP1;
          end
        end
        S_IP1: begin
          w_cnt_inc = 1'b1;
          if (w_boundary) begin
            w_done_err   = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_ld_ip      = 1'b1;
            w_next_state = S_IP2;
          end
        end
        S_IP2: begin
          w_cnt_inc = 1'b1;
          if (w_boundary) begin
            w_done_err   = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_NDN;
          end
        end
        S_NDN: begin
          w_cnt_inc = 1'b1;
          if (w_boundary) begin
            w_done_err   = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_ld_ndn     = 1'b1;
            w_next_state = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          w_cnt_inc = 1'b1;
          if (w_boundary) begin
            w_done_ok    = 1'b1;
            w_next_state = S_IDLE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data     <= '0;
      r_out_ctrl     <= '0;
      r_out_wr       <= 1'b0;
      r_cnt          <= '0;
      r_ip_len_nxt   <= '0;
      r_ndn_type_nxt <= '0;
      r_ndn_len_nxt  <= '0;
      r_hdr_valid    <= 1'b0;
      r_ip_len       <= '0;
      r_ndn_type     <= '0;
      r_ndn_len      <= '0;
      r_word_cnt     <= '0;
      r_type_match   <= 1'b0;
      r_pkt_err      <= 1'b0;
    end else begin
      r_out_wr <= w_accept;
      if (w_accept) begin
        r_out_data <= bus.in_data;
        r_out_ctrl <= bus.in_ctrl;
      end

      if (w_cnt_load) begin
        r_cnt <= 8'd1;
      end else if (w_cnt_inc) begin
        r_cnt <= w_cnt_sat;
      end

      if (w_ld_ip) begin
        r_ip_len_nxt <= bus.in_data[47:32];
      end
      if (w_ld_ndn) begin
        r_ndn_type_nxt <= bus.in_data[63:32];
        r_ndn_len_nxt  <= bus.in_data[31:16];
      end

      // The terminating word is itself counted, hence w_cnt_sat rather than r_cnt.
      r_hdr_valid <= w_done_ok || w_done_err;
      if (w_done_ok) begin
        r_ip_len     <= r_ip_len_nxt;
        r_ndn_type   <= r_ndn_type_nxt;
        r_ndn_len    <= r_ndn_len_nxt;
        r_word_cnt   <= w_cnt_sat;
        r_type_match <= (r_ndn_type_nxt == NDN_TYPE);
        r_pkt_err    <= 1'b0;
      end else if (w_done_err) begin
        r_word_cnt   <= w_cnt_sat;
        r_pkt_err    <= 1'b1;
      end
    end
  end

`ifdef NDN_PARSER_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_done_ok) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      if (w_done_err) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign pkt_cnt = r_pkt_cnt;
  assign err_cnt = r_err_cnt;
`endif

  assign bus.out_data = r_out_data;
  assign bus.out_ctrl = r_out_ctrl;
  assign bus.out_wr   = r_out_wr;
  assign hdr_valid    = r_hdr_valid;
  assign ip_len       = r_ip_len;
  assign ndn_type     = r_ndn_type;
  assign ndn_len      = r_ndn_len;
  assign word_cnt     = r_word_cnt;
  assign type_match   = r_type_match;
  assign pkt_err      = r_pkt_err;

endmodule

// File: tb/tb_ndn_pkt_parser.sv
// Directed self-checking bench for ndn_pkt_parser: good, mismatched, truncated, stalled, reset and long packets.
`timescale 1ns/1ps
module tb_ndn_pkt_parser;

  localparam logic [31:0] EXP_TYPE = 32'h89ABCDEF;
  localparam logic [63:0] IP_WORD  = 64'h4500007600010000;
  localparam logic [63:0] NDN_A    = 64'h89ABCDEF06605468;
  localparam logic [63:0] NDN_B    = 64'h1234567800100000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ndn_pkt_parser_if u_if ();

  logic        hdr_valid;
  logic [15:0] ip_len;
  logic [31:0] ndn_type;
  logic [15:0] ndn_len;
  logic [7:0]  word_cnt;
  logic        type_match;
  logic        pkt_err;
`ifdef NDN_PARSER_STATS_EN
  logic [31:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic [31:0] pkt_cnt_before;
  logic [15:0] err_cnt_before;
`endif

  ndn_pkt_parser #(.NDN_TYPE(EXP_TYPE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (u_if),
    .hdr_valid  (hdr_valid),
    .ip_len     (ip_len),
    .ndn_type   (ndn_type),
    .ndn_len    (ndn_len),
    .word_cnt   (word_cnt),
    .type_match (type_match),
    .pkt_err    (pkt_err)
`ifdef NDN_PARSER_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;
  int hv_cnt  = 0;
  int hv0;

  logic [15:0] cap_ip_len;
  logic [31:0] cap_ndn_type;
  logic [15:0] cap_ndn_len;
  logic [7:0]  cap_word_cnt;
  logic        cap_type_match;
  logic        cap_pkt_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Every high cycle of hdr_valid is counted, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (hdr_valid === 1'b1) begin
      hv_cnt++;
      cap_ip_len     = ip_len;
      cap_ndn_type   = ndn_type;
      cap_ndn_len    = ndn_len;
      cap_word_cnt   = word_cnt;
      cap_type_match = type_match;
      cap_pkt_err    = pkt_err;
    end
  end

  task automatic drive(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    u_if.in_data = d;
    u_if.in_ctrl = c;
    u_if.in_wr   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      u_if.in_wr   = 1'b0;
      u_if.in_ctrl = 8'h00;
    end
    #2;
  endtask

  // Holds a boundary word on the bus with out_rdy low; it must never be taken.
  task automatic stall(input int n);
    @(negedge clk);
    u_if.out_rdy = 1'b0;
    u_if.in_data = 64'hDEADBEEFDEADBEEF;
    u_if.in_ctrl = 8'h01;
    u_if.in_wr   = 1'b1;
    #1 check("stall_in_rdy", 64'(u_if.in_rdy), 64'd0);
    repeat (n) begin
      @(negedge clk);
      check("stall_out_wr", 64'(u_if.out_wr), 64'd0);
    end
    u_if.out_rdy = 1'b1;
    u_if.in_wr   = 1'b0;
    u_if.in_ctrl = 8'h00;
  endtask

  task automatic send_pkt(input logic [63:0] ndn_w, input int npay, input int stall_at);
    drive(64'h00000000000000A1, 8'h01);
    drive(IP_WORD, 8'h00);
    drive(64'h0000000000000000, 8'h00);
    drive(ndn_w, 8'h00);
    for (int i = 0; i < npay; i++) begin
      drive(64'h1000 + 64'(i), 8'h00);
      if (i == stall_at) stall(5);
    end
    drive(64'h0000000000000E0F, 8'h01);
    idle(3);
  endtask

  task automatic expect_hdr(input string p, input logic [15:0] ip, input logic [31:0] t,
                            input logic [15:0] nl, input logic [7:0] wc, input logic tm,
                            input logic err);
    check({p, "_pulses"},     64'(hv_cnt - hv0), 64'd1);
    check({p, "_ip_len"},     64'(cap_ip_len), 64'(ip));
    check({p, "_ndn_type"},   64'(cap_ndn_type), 64'(t));
    check({p, "_ndn_len"},    64'(cap_ndn_len), 64'(nl));
    check({p, "_word_cnt"},   64'(cap_word_cnt), 64'(wc));
    check({p, "_type_match"}, 64'(cap_type_match), 64'(tm));
    check({p, "_pkt_err"},    64'(cap_pkt_err), 64'(err));
  endtask

  initial begin
    rst          = 1'b1;
    u_if.in_data = '0;
    u_if.in_ctrl = '0;
    u_if.in_wr   = 1'b0;
    u_if.out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_wr",    64'(u_if.out_wr), 64'd0);
    check("rst_out_data",  u_if.out_data, 64'd0);
    check("rst_out_ctrl",  64'(u_if.out_ctrl), 64'd0);
    check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("rst_ip_len",    64'(ip_len), 64'd0);
    check("rst_ndn_type",  64'(ndn_type), 64'd0);
    check("rst_word_cnt",  64'(word_cnt), 64'd0);
    check("rst_pkt_err",   64'(pkt_err), 64'd0);
`ifdef NDN_PARSER_STATS_EN
    check("rst_pkt_cnt",   64'(pkt_cnt), 64'd0);
    check("rst_err_cnt",   64'(err_cnt), 64'd0);
`endif
    rst = 1'b0;

    u_if.out_rdy = 1'b0;
    #1 check("rdy_follow_lo", 64'(u_if.in_rdy), 64'd0);
    u_if.out_rdy = 1'b1;
    #1 check("rdy_follow_hi", 64'(u_if.in_rdy), 64'd1);

    // A stray ctrl==0 word while idle is forwarded after one cycle but starts nothing.
    hv0 = hv_cnt;
    drive(64'h0123456789ABCDEF, 8'h00);
    @(posedge clk);
    #1;
    check("fwd_out_wr",   64'(u_if.out_wr), 64'd1);
    check("fwd_out_data", u_if.out_data, 64'h0123456789ABCDEF);
    check("fwd_out_ctrl", 64'(u_if.out_ctrl), 64'd0);
    idle(2);
    check("fwd_out_wr_off", 64'(u_if.out_wr), 64'd0);
    check("fwd_no_pulse",   64'(hv_cnt - hv0), 64'd0);

    hv0 = hv_cnt;
    send_pkt(NDN_A, 5, -1);
    expect_hdr("pkt_a", 16'h0076, 32'h89ABCDEF, 16'h0660, 8'd10, 1'b1, 1'b0);
    idle(5);
    check("hold_ip_len",   64'(ip_len), 64'h0076);
    check("hold_word_cnt", 64'(word_cnt), 64'd10);
    check("hold_hdr_low",  64'(hdr_valid), 64'd0);

    hv0 = hv_cnt;
    send_pkt(NDN_B, 5, -1);
    expect_hdr("pkt_b", 16'h0076, 32'h12345678, 16'h0010, 8'd10, 1'b0, 1'b0);

`ifdef NDN_PARSER_STATS_EN
    err_cnt_before = err_cnt;
`endif
    hv0 = hv_cnt;
    drive(64'h00000000000000A1, 8'h01);
    drive(64'h0000ABCD00000000, 8'h00);
    drive(64'h0000000000000E0F, 8'h01);
    idle(3);
    expect_hdr("trunc", 16'h0076, 32'h12345678, 16'h0010, 8'd3, 1'b0, 1'b1);
`ifdef NDN_PARSER_STATS_EN
    check("trunc_err_cnt", 64'(err_cnt), 64'(err_cnt_before + 16'd1));
`endif

    hv0 = hv_cnt;
    send_pkt(NDN_A, 5, 2);
    expect_hdr("stall", 16'h0076, 32'h89ABCDEF, 16'h0660, 8'd10, 1'b1, 1'b0);

    hv0 = hv_cnt;
    drive(64'h00000000000000A1, 8'h01);
    drive(IP_WORD, 8'h00);
    drive(64'h0000000000000000, 8'h00);
    drive(NDN_B, 8'h00);
    drive(64'h0000000000001000, 8'h00);
    @(negedge clk);
    rst        = 1'b1;
    u_if.in_wr = 1'b0;
    @(negedge clk);
    check("midrst_ip_len",   64'(ip_len), 64'd0);
    check("midrst_word_cnt", 64'(word_cnt), 64'd0);
    check("midrst_out_wr",   64'(u_if.out_wr), 64'd0);
    rst = 1'b0;
    send_pkt(NDN_A, 5, -1);
    expect_hdr("midrst", 16'h0076, 32'h89ABCDEF, 16'h0660, 8'd10, 1'b1, 1'b0);

`ifdef NDN_PARSER_STATS_EN
    pkt_cnt_before = pkt_cnt;
`endif
    hv0 = hv_cnt;
    send_pkt(NDN_A, 300, -1);
    expect_hdr("long", 16'h0076, 32'h89ABCDEF, 16'h0660, 8'd255, 1'b1, 1'b0);
`ifdef NDN_PARSER_STATS_EN
    check("long_pkt_cnt", 64'(pkt_cnt), 64'(pkt_cnt_before + 32'd1));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ndn_pkt_parser.md
NDN_PKT_PARSER -- requirements
Module: ndn_pkt_parser

Interface
REQ-001 SHALL have parameter NDN_TYPE, default 32'h89ABCDEF, the expected NDN TLV type word.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  64  upstream packet word.
REQ-005 SHALL have port in_ctrl  input  8  upstream control; non-zero marks a packet boundary word.
REQ-006 SHALL have port in_wr  input  1  upstream word valid.
REQ-007 SHALL have port in_rdy  output  1  ready to upstream.
REQ-008 SHALL have ports out_data, out_ctrl, out_wr (output 64/8/1) and out_rdy (input 1), a pass-through stream with the same semantics.
REQ-009 SHALL have port hdr_valid  output  1  one-cycle pulse when a packet completes parsing.
REQ-010 SHALL have ports ip_len (output 16), ndn_type (output 32), ndn_len (output 16), word_cnt (output 8), type_match (output 1) and pkt_err (output 1), holding the parse results.

Function
REQ-011 SHALL drive in_rdy = out_rdy combinationally; a word is accepted when in_wr && in_rdy.
REQ-012 SHALL register each accepted word to out_data/out_ctrl with out_wr=1 one cycle later, and drive out_wr=0 on cycles with no accept; latency is exactly 1 cycle and there is no buffering.
REQ-013 SHALL implement FSM states IDLE, IP1, IP2, NDN, PAYLOAD.
REQ-014 IDLE: an accepted word with in_ctrl!=0 (module header) SHALL move to IP1 and load word counter=1; an accepted word with in_ctrl==0 SHALL be forwarded, otherwise ignored, and SHALL remain in IDLE.
REQ-015 IP1: an accepted ctrl==0 word SHALL latch ip_len_next=in_data[47:32] -> IP2.
REQ-016 IP2: an accepted ctrl==0 word SHALL -> NDN, with no fields latched.
REQ-017 NDN: an accepted ctrl==0 word SHALL latch ndn_type_next=in_data[63:32] and ndn_len_next=in_data[31:16] -> PAYLOAD.
REQ-018 PAYLOAD: ctrl==0 words SHALL only count; an accepted ctrl!=0 word is EOP and SHALL -> IDLE.
REQ-019 On EOP, the next cycle SHALL pulse hdr_valid=1, update ip_len/ndn_type/ndn_len/word_cnt from the latched values, set type_match=(ndn_type==NDN_TYPE), and set pkt_err=0.
REQ-020 An accepted ctrl!=0 word in IP1, IP2 or NDN (truncated packet) SHALL -> IDLE, and the next cycle SHALL pulse hdr_valid=1 with pkt_err=1, word_cnt updated, and other fields unchanged.
REQ-021 The word counter SHALL count every accepted word from module header to EOP inclusive, and SHALL saturate at 255 with no wrap.
REQ-022 Result outputs SHALL hold their values between hdr_valid pulses.
REQ-023 Cycles with in_wr=0 or out_rdy=0 SHALL leave FSM state and counters unchanged.

Reset
REQ-024 Reset SHALL force state=IDLE, out_wr=0, out_data=0, out_ctrl=0, hdr_valid=0, all result outputs=0 and all counters=0.
REQ-025 Reset asserted mid-packet SHALL abandon the packet without a hdr_valid pulse, and parsing SHALL restart at the next ctrl!=0 word.

Configuration
REQ-026 When macro NDN_PARSER_STATS_EN is defined, the block SHALL add outputs pkt_cnt (32 bits, count of error-free hdr_valid pulses) and err_cnt (16 bits, count of pkt_err pulses); both SHALL wrap modulo 2^width and clear on reset.
REQ-027 When NDN_PARSER_STATS_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover: 10-word packet with ctrl=1,0x8,...,0,1, word1=64'h4500007600010000, word3=64'h89ABCDEF06605468, out_rdy=1 -> one hdr_valid with ip_len=16'h0076, ndn_type=32'h89ABCDEF, ndn_len=16'h0660, word_cnt=10, type_match=1, pkt_err=0.
REQ-029 SHALL cover: the same packet with word3=64'h1234567800100000 -> type_match=0, ndn_len=16'h0010, pkt_err=0.
REQ-030 SHALL cover: 3-word packet with ctrl=1,0,1 -> hdr_valid with pkt_err=1, word_cnt=3, ip_len unchanged from the previous packet.
REQ-031 SHALL cover: out_rdy=0 for 5 cycles mid-payload with in_wr=1 -> in_rdy=0, out_wr=0, no state change; on release, results are identical to the first scenario.
REQ-032 SHALL cover: rst pulsed after word 5, then a full packet -> exactly one hdr_valid, for the second packet only, with word_cnt=10.
REQ-033 SHALL cover: 300-word payload packet -> word_cnt=255, pkt_err=0; with NDN_PARSER_STATS_EN defined, pkt_cnt increments by 1.
